// File: rtl/calc_pkg.sv
// Shared types and constants for the parameter calculator.
package calc_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD     = 2'd0,
        OP_SUB     = 2'd1,
        OP_MUL_AND = 2'd2,
        OP_XOR     = 2'd3
    } op_t;

    localparam logic [1:0] DM_RES = 2'd0;
    localparam logic [1:0] DM_A   = 2'd1;
    localparam logic [1:0] DM_B   = 2'd2;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a button level already synchronous to clk.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic r_prev;

    // Cleared on reset so a button held through reset yields one event at release.
    always_ff @(posedge clk) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= level;
    end

    assign pulse = level & ~r_prev;

endmodule

// File: rtl/param_calculator.sv
// Two-operand calculator FSM with display mux; define CALC_MUL_EN to make opcode 10 a multiply
// (otherwise it is bitwise AND).
module param_calculator
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       op_sel,
    input  logic             confirm,
    input  logic             mode_change,
    output logic [WIDTH-1:0] disp_val,
    output logic [1:0]       disp_mode,
    output logic [1:0]       state_o,
    output logic             valid,
    output logic             ovf
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_res;
    logic             r_ovf;
    logic [1:0]       r_disp_mode;

    logic             w_conf;
    logic             w_mode;
    logic             w_load_b;
    logic [WIDTH-1:0] w_b;
    logic [1:0]       w_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    btn_edge u_conf_edge (.clk(clk), .reset(reset), .level(confirm),     .pulse(w_conf));
    btn_edge u_mode_edge (.clk(clk), .reset(reset), .level(mode_change), .pulse(w_mode));

    // The ALU sees the incoming operand/opcode on the loading edge, so the result
    // lands on the same edge as opB/op without an extra cycle.
    assign w_load_b = w_conf && (r_state == S_B);
    assign w_b      = w_load_b ? sw     : r_opB;
    assign w_op     = w_load_b ? op_sel : r_op;
    assign w_sum    = {1'b0, r_opA} + {1'b0, w_b};

`ifdef CALC_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = {{WIDTH{1'b0}}, r_opA} * {{WIDTH{1'b0}}, w_b};
`endif

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_ovf = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = r_opA - w_b;
                w_ovf = (r_opA < w_b);
            end
            OP_MUL_AND: begin
`ifdef CALC_MUL_EN
                w_res = w_prod[WIDTH-1:0];
                w_ovf = |w_prod[2*WIDTH-1:WIDTH];
`else
                w_res = r_opA & w_b;
                w_ovf = 1'b0;
`endif
            end
            default: begin
                w_res = r_opA ^ w_b;
                w_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_A;
            r_opA   <= '0;
            r_opB   <= '0;
            r_op    <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_conf) begin
            case (r_state)
                S_A: begin
                    r_opA   <= sw;
                    r_state <= S_B;
                end
                S_B: begin
                    r_opB   <= sw;
                    r_op    <= op_sel;
                    r_res   <= w_res;
                    r_ovf   <= w_ovf;
                    r_state <= S_RES;
                end
                S_RES: begin
                    r_opA   <= r_res;
                    r_state <= S_B;
                end
                default: r_state <= S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_mode <= DM_RES;
        end else if (w_mode) begin
            case (r_disp_mode)
                DM_RES:  r_disp_mode <= DM_A;
                DM_A:    r_disp_mode <= DM_B;
                default: r_disp_mode <= DM_RES;
            endcase
        end
    end

    always_comb begin
        case (r_disp_mode)
            DM_A:    disp_val = r_opA;
            DM_B:    disp_val = r_opB;
            default: disp_val = (r_state == S_RES) ? r_res : sw;
        endcase
    end

    assign disp_mode = r_disp_mode;
    assign state_o   = r_state;
    assign valid     = (r_state == S_RES);
    assign ovf       = r_ovf;

endmodule
